pe_mb: RTL and testbench

//  Second-generation systolic processing element. It is parametrised in operand and accumulator width.
//  It holds a W_SLOTS-deep queue of preloaded weights, so several tiles can be prefetched before use.
//  It runs in two modes: weight-stationary (WS) and output-stationary (OS, with drain).

---
 rtl/pe_mb.sv | 199 +++++++++++++++++++
 tb/tb_pe_mb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mb.sv
// pe_mb: second-generation systolic processing element.
//   Weight-stationary (WS) and output-stationary (OS) modes, a W_SLOTS-deep
//   weight prefetch queue, and optional saturation of accumulate results.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   pe_enabled                      0 freezes state, strobes register 0
//   pe_mode                         0=WS, 1=OS (registered into mode_q)
//   pe_input_in/pe_valid_in         activation from the left
//   pe_switch_in                    pop next queued weight into active
//   pe_weight_in/pe_accept_w_in     weight push (WS) / streaming operand (OS)
//   pe_psum_in                      partial sum from above
//   pe_drain_in                     OS: emit accumulator and clear it
//   pe_*_out mirrors                the matching inputs delayed one cycle
//   pe_psum_out/pe_psum_valid_out   result to the PE below
//   pe_w_full                       weight queue holds W_SLOTS entries
//   pe_w_err                        sticky push-when-full / pop-when-empty
module pe_mb #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned W_SLOTS = 4,
  parameter int unsigned SAT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pe_enabled,
  input  logic              pe_mode,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic              pe_valid_in,
  input  logic              pe_switch_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_accept_w_in,
  input  logic [ACC_W-1:0]  pe_psum_in,
  input  logic              pe_drain_in,
  output logic [DATA_W-1:0] pe_input_out,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic              pe_accept_w_out,
  output logic              pe_drain_out,
  output logic [ACC_W-1:0]  pe_psum_out,
  output logic              pe_psum_valid_out,
  output logic              pe_w_full,
  output logic              pe_w_err
);

  localparam int unsigned PTR_W = (W_SLOTS > 1) ? $clog2(W_SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(W_SLOTS + 1);

  typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} mode_e;

  logic [DATA_W-1:0] input_q, input_d, weight_q, weight_d;
  logic              valid_q, valid_d, switch_q, switch_d;
  logic              accept_q, accept_d, drain_q, drain_d;
  logic [ACC_W-1:0]  psum_q, psum_d, acc_q, acc_d;
  logic              psum_valid_q, psum_valid_d;
  logic              err_q, err_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] active_w_q, active_w_d;
  logic [DATA_W-1:0] mem_q [W_SLOTS];
  logic [DATA_W-1:0] mem_d [W_SLOTS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                     full, empty, push_ok, pop_ok;
  logic signed [2*DATA_W-1:0] ws_prod, os_prod;
  logic [ACC_W-1:0]         ws_ext, os_ext;

  assign full    = (cnt_q == CNT_W'(W_SLOTS));
  assign empty   = (cnt_q == '0);
  assign ws_prod = $signed(pe_input_in) * $signed(active_w_q);
  assign os_prod = $signed(pe_input_in) * $signed(pe_weight_in);
  assign ws_ext  = ACC_W'(ws_prod);
  assign os_ext  = ACC_W'(os_prod);

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(W_SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // One extra bit catches overflow: the top two bits disagree on overflow.
  function automatic logic [ACC_W-1:0] add_sat(logic [ACC_W-1:0] a, logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (SAT_EN != 0 && s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  always_comb begin
    input_d      = input_q;
    weight_d     = weight_q;
    valid_d      = 1'b0;
    switch_d     = 1'b0;
    accept_d     = 1'b0;
    drain_d      = 1'b0;
    psum_d       = psum_q;
    psum_valid_d = 1'b0;
    acc_d        = acc_q;
    err_d        = err_q;
    mode_d       = mode_q;
    active_w_d   = active_w_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    pop_ok       = 1'b0;
    push_ok      = 1'b0;
    if (pe_enabled) begin
      input_d  = pe_input_in;
      weight_d = pe_weight_in;
      valid_d  = pe_valid_in;
      switch_d = pe_switch_in;
      accept_d = pe_accept_w_in;
      drain_d  = pe_drain_in;
      mode_d   = mode_e'(pe_mode);

      // A same-cycle pop frees the slot, so push-when-full is legal with it.
      pop_ok  = pe_switch_in && !empty;
      push_ok = pe_accept_w_in && (!full || pop_ok);
      if ((pe_switch_in && empty) || (pe_accept_w_in && !push_ok))
        err_d = 1'b1;
      if (push_ok) begin
        mem_d[wr_ptr_q] = pe_weight_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        active_w_d = mem_q[rd_ptr_q];
        rd_ptr_d   = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

      if (mode_e'(pe_mode) != mode_q) begin
        acc_d  = '0;
        psum_d = '0;
      end else if (mode_q == MODE_WS) begin
        psum_d       = pe_valid_in ? add_sat(pe_psum_in, ws_ext) : '0;
        psum_valid_d = pe_valid_in;
      end else if (pe_drain_in) begin
        psum_d       = acc_q;
        psum_valid_d = 1'b1;
        acc_d        = pe_valid_in ? os_ext : '0;
      end else begin
        psum_d = pe_psum_in;
        if (pe_valid_in)
          acc_d = add_sat(acc_q, os_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_q      <= '0;
      weight_q     <= '0;
      valid_q      <= 1'b0;
      switch_q     <= 1'b0;
      accept_q     <= 1'b0;
      drain_q      <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      mode_q       <= MODE_WS;
      active_w_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < W_SLOTS; i++)
        mem_q[i] <= '0;
    end else begin
      input_q      <= input_d;
      weight_q     <= weight_d;
      valid_q      <= valid_d;
      switch_q     <= switch_d;
      accept_q     <= accept_d;
      drain_q      <= drain_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      mode_q       <= mode_d;
      active_w_q   <= active_w_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign pe_input_out      = input_q;
  assign pe_valid_out      = valid_q;
  assign pe_switch_out     = switch_q;
  assign pe_weight_out     = weight_q;
  assign pe_accept_w_out   = accept_q;
  assign pe_drain_out      = drain_q;
  assign pe_psum_out       = psum_q;
  assign pe_psum_valid_out = psum_valid_q;
  assign pe_w_full         = full;
  assign pe_w_err          = err_q;

endmodule

// File: tb/tb_pe_mb.sv
// tb_pe_mb: self-checking bench for pe_mb. Main instance uses default
// parameters; two ACC_W=16 instances (saturating and wrapping) share the
// control inputs and check the overflow behaviour.
module tb_pe_mb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, mode, valid, sw, accw, drain;
  logic [7:0]  in_i, w_i;
  logic [31:0] psum_i;
  logic [15:0] psum16_i;

  logic [7:0]  in_o, w_o;
  logic        valid_o, sw_o, accw_o, drain_o, pv_o, full_o, err_o;
  logic [31:0] psum_o;

  logic [7:0]  s_in_o, s_w_o, r_in_o, r_w_o;
  logic        s_v_o, s_sw_o, s_a_o, s_d_o, s_pv_o, s_f_o, s_e_o;
  logic        r_v_o, r_sw_o, r_a_o, r_d_o, r_pv_o, r_f_o, r_e_o;
  logic [15:0] s_psum_o, r_psum_o;

  pe_mb #(.DATA_W(8), .ACC_W(32), .W_SLOTS(4), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .pe_enabled(en), .pe_mode(mode),
    .pe_input_in(in_i), .pe_valid_in(valid), .pe_switch_in(sw),
    .pe_weight_in(w_i), .pe_accept_w_in(accw), .pe_psum_in(psum_i),
    .pe_drain_in(drain), .pe_input_out(in_o), .pe_valid_out(valid_o),
    .pe_switch_out(sw_o), .pe_weight_out(w_o), .pe_accept_w_out(accw_o),
    .pe_drain_out(drain_o), .pe_psum_out(psum_o), .pe_psum_valid_out(pv_o),
    .pe_w_full(full_o), .pe_w_err(err_o));

  pe_mb #(.DATA_W(8), .ACC_W(16), .W_SLOTS(4), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pe_enabled(en), .pe_mode(mode),
    .pe_input_in(in_i), .pe_valid_in(valid), .pe_switch_in(sw),
    .pe_weight_in(w_i), .pe_accept_w_in(accw), .pe_psum_in(psum16_i),
    .pe_drain_in(drain), .pe_input_out(s_in_o), .pe_valid_out(s_v_o),
    .pe_switch_out(s_sw_o), .pe_weight_out(s_w_o), .pe_accept_w_out(s_a_o),
    .pe_drain_out(s_d_o), .pe_psum_out(s_psum_o), .pe_psum_valid_out(s_pv_o),
    .pe_w_full(s_f_o), .pe_w_err(s_e_o));

  pe_mb #(.DATA_W(8), .ACC_W(16), .W_SLOTS(4), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pe_enabled(en), .pe_mode(mode),
    .pe_input_in(in_i), .pe_valid_in(valid), .pe_switch_in(sw),
    .pe_weight_in(w_i), .pe_accept_w_in(accw), .pe_psum_in(psum16_i),
    .pe_drain_in(drain), .pe_input_out(r_in_o), .pe_valid_out(r_v_o),
    .pe_switch_out(r_sw_o), .pe_weight_out(r_w_o), .pe_accept_w_out(r_a_o),
    .pe_drain_out(r_d_o), .pe_psum_out(r_psum_o), .pe_psum_valid_out(r_pv_o),
    .pe_w_full(r_f_o), .pe_w_err(r_e_o));

  typedef struct {
    string       name;
    bit          rst, en, mode, valid, sw, accw, drain;
    logic [7:0]  in, w;
    logic [31:0] psum, exp_psum;
    bit          exp_pv;
    bit          chk16;
    logic [15:0] psum16, exp_s16, exp_r16;
    bit          chk_fe, exp_full, exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] psum;
    bit          pv, chk16;
    logic [15:0] s16, r16;
    bit          chk_fe, full, err;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] prev_in = '0;
  logic [7:0] prev_w = '0;

  function automatic vec_t mk(string n, bit e, bit m, bit v, bit s, bit a, bit d,
                              int in, int w, int psum, int ep, bit epv);
    vec_t t;
    t.name = n; t.rst = 0; t.en = e; t.mode = m; t.valid = v; t.sw = s;
    t.accw = a; t.drain = d; t.in = in[7:0]; t.w = w[7:0]; t.psum = psum;
    t.exp_psum = ep; t.exp_pv = epv; t.chk16 = 0; t.psum16 = '0;
    t.exp_s16 = '0; t.exp_r16 = '0; t.chk_fe = 0; t.exp_full = 0; t.exp_err = 0;
    return t;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, $signed(act), $signed(exp));
    end
  endtask

  task automatic do_reset();
    en = 0; mode = 0; valid = 0; sw = 0; accw = 0; drain = 0;
    in_i = '0; w_i = '0; psum_i = '0; psum16_i = '0;
    rst_n = 0;
    #2;
    check("reset.psum", psum_o, 32'd0);
    check("reset.outs", {9'd0, in_o, w_o, valid_o, sw_o, accw_o, drain_o, pv_o, full_o, err_o}, 32'd0);
    check("reset.psum16", {s_psum_o, r_psum_o}, 32'd0);
    #2;
    rst_n = 1;
    prev_in = '0;
    prev_w  = '0;
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    if (v.rst) do_reset();
    en = v.en; mode = v.mode; valid = v.valid; sw = v.sw; accw = v.accw;
    drain = v.drain; in_i = v.in; w_i = v.w; psum_i = v.psum; psum16_i = v.psum16;
    sb.push_back('{v.name, v.exp_psum, v.exp_pv, v.chk16, v.exp_s16, v.exp_r16,
                   v.chk_fe, v.exp_full, v.exp_err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".psum"}, psum_o, e.psum);
    check({e.name, ".pv"}, {31'd0, pv_o}, {31'd0, e.pv});
    if (e.chk16) begin
      check({e.name, ".sat16"}, {16'd0, s_psum_o}, {16'd0, e.s16});
      check({e.name, ".wrap16"}, {16'd0, r_psum_o}, {16'd0, e.r16});
    end
    if (e.chk_fe) begin
      check({e.name, ".full"}, {31'd0, full_o}, {31'd0, e.full});
      check({e.name, ".err"}, {31'd0, err_o}, {31'd0, e.err});
    end
    if (v.en) begin
      check({v.name, ".fwd"}, {12'd0, in_o, w_o, valid_o, sw_o, accw_o, drain_o},
            {12'd0, v.in, v.w, v.valid, v.sw, v.accw, v.drain});
      prev_in = v.in;
      prev_w  = v.w;
    end else begin
      check({v.name, ".hold"}, {12'd0, in_o, w_o, valid_o, sw_o, accw_o, drain_o},
            {12'd0, prev_in, prev_w, 4'd0});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t;
    int   popped [16];

    // ---- vector table ----
    // WS basic
    t = mk("t1.push5", 1,0,0,0,1,0, 0,5,0, 0,0); t.rst = 1; vecs.push_back(t);
    vecs.push_back(mk("t1.sw",   1,0,0,1,0,0, 0,0,0, 0,0));
    vecs.push_back(mk("t1.mac1", 1,0,1,0,0,0, 3,0,10, 25,1));
    vecs.push_back(mk("t1.mac2", 1,0,1,0,0,0, -2,0,100, 90,1));
    vecs.push_back(mk("t1.idle", 1,0,0,0,0,0, 0,0,77, 0,0));
    // Queue fill, overflow, drain order, underflow (old active weight is 5)
    for (int k = 1; k <= 4; k++) vecs.push_back(mk("t2.push", 1,0,0,0,1,0, 0,k,0, 0,0));
    vecs[$].chk_fe = 1; vecs[$].exp_full = 1; vecs[$].exp_err = 0;
    t = mk("t2.push9", 1,0,0,0,1,0, 0,9,0, 0,0);
    t.chk_fe = 1; t.exp_full = 1; t.exp_err = 1; vecs.push_back(t);
    vecs.push_back(mk("t2.pop0", 1,0,1,1,0,0, 1,0,0, 5,1));
    vecs.push_back(mk("t2.pop1", 1,0,1,1,0,0, 1,0,0, 1,1));
    vecs.push_back(mk("t2.pop2", 1,0,1,1,0,0, 1,0,0, 2,1));
    vecs.push_back(mk("t2.pop3", 1,0,1,1,0,0, 1,0,0, 3,1));
    vecs.push_back(mk("t2.pop4", 1,0,1,1,0,0, 1,0,0, 4,1));
    t = mk("t2.after", 1,0,1,0,0,0, 1,0,0, 4,1);
    t.chk_fe = 1; t.exp_full = 0; t.exp_err = 1; vecs.push_back(t);
    // Saturation / wrap with ACC_W=16
    t = mk("t4.push127", 1,0,0,0,1,0, 0,127,0, 0,0); t.rst = 1; vecs.push_back(t);
    vecs.push_back(mk("t4.sw", 1,0,0,1,0,0, 0,0,0, 0,0));
    t = mk("t4.pos", 1,0,1,0,0,0, 127,0,32760, 48889,1);
    t.chk16 = 1; t.psum16 = 16'd32760; t.exp_s16 = 16'h7FFF; t.exp_r16 = 16'hBEF9; vecs.push_back(t);
    t = mk("t4.neg", 1,0,1,0,0,0, -128,0,-32760, -49016,1);
    t.chk16 = 1; t.psum16 = 16'h8008; t.exp_s16 = 16'h8000; t.exp_r16 = 16'h4088; vecs.push_back(t);
    // OS accumulate, drain with same-cycle product, pass-through
    t = mk("t5.modechg", 1,1,0,0,0,0, 0,0,0, 0,0); t.rst = 1; vecs.push_back(t);
    vecs.push_back(mk("t5.p1",     1,1,1,0,0,0, 2,3,7, 7,0));
    vecs.push_back(mk("t5.p2",     1,1,1,0,0,0, 4,-1,8, 8,0));
    vecs.push_back(mk("t5.p3",     1,1,1,0,0,0, 5,5,9, 9,0));
    vecs.push_back(mk("t5.drain",  1,1,1,0,0,1, 1,1,0, 27,1));
    vecs.push_back(mk("t5.pass",   1,1,0,0,0,0, 0,0,-5, -5,0));
    vecs.push_back(mk("t5.drain2", 1,1,0,0,0,1, 0,0,0, 1,1));
    // Disabled cycles mid-tile: everything ignored, acc holds
    vecs.push_back(mk("t6.p", 1,1,1,0,0,0, 3,3,42, 42,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk("t6.off", 0,1,1,1,1,1, 7,7,99, 42,0));
    vecs[$].chk_fe = 1; vecs[$].exp_full = 0; vecs[$].exp_err = 0;
    vecs.push_back(mk("t6.on",    1,1,1,0,0,0, 2,2,0, 0,0));
    vecs.push_back(mk("t6.drain", 1,1,0,0,0,1, 0,0,0, 13,1));
    // Fill queue and accumulate, then reset mid-tile
    for (int k = 0; k < 4; k++) vecs.push_back(mk("t6.fill", 1,1,1,0,1,0, 1,5,0, 0,0));
    vecs[$].chk_fe = 1; vecs[$].exp_full = 1; vecs[$].exp_err = 0;
    t = mk("t6.rst.mode", 1,1,0,0,0,0, 0,0,0, 0,0); t.rst = 1;
    t.chk_fe = 1; t.exp_full = 0; t.exp_err = 0; vecs.push_back(t);
    vecs.push_back(mk("t6.rst.drain", 1,1,0,0,0,1, 0,0,0, 0,1));
    t = mk("t6.popempty", 1,1,0,1,0,0, 0,0,0, 0,0);
    t.chk_fe = 1; t.exp_full = 0; t.exp_err = 1; vecs.push_back(t);

    rst_n = 0; en = 0; mode = 0; valid = 0; sw = 0; accw = 0; drain = 0;
    in_i = '0; w_i = '0; psum_i = '0; psum16_i = '0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Full queue push+pop together over four laps of the pointers
    for (int k = 0; k < 16; k++) popped[k] = (k < 4) ? k + 1 : 10 + k - 4;
    t = mk("t3.push", 1,0,0,0,1,0, 0,1,0, 0,0); t.rst = 1; apply(t);
    for (int k = 2; k <= 4; k++) apply(mk("t3.push", 1,0,0,0,1,0, 0,k,0, 0,0));
    for (int j = 0; j < 16; j++) begin
      t = mk("t3.pp", 1,0,1,1,1,0, 1,10+j,0, (j == 0) ? 0 : popped[j-1], 1);
      t.chk_fe = 1; t.exp_full = 1; t.exp_err = 0;
      apply(t);
    end
    t = mk("t3.last", 1,0,1,0,0,0, 1,0,0, popped[15], 1);
    t.chk_fe = 1; t.exp_full = 1; t.exp_err = 0;
    apply(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
